// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the core's load/store path and dmem_lsu.
// The core drives the master side; the memory block is the slave.
interface dmem_lsu_if;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        init_done;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I data memory with byte/half/word load-store formatting and a post-reset clear sequence.
// Define DMEM_LSU_REG_READ_EN to register the response path (one cycle load latency).
module dmem_lsu #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic    clk,
   input  logic    rst_n,
   dmem_lsu_if.slave bus
);

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic [AW-1:0]  r_clrCnt;
   logic [31:0]    r_mem [DEPTH_WORDS];

   logic           w_ready;
   logic           w_initDone;
   logic           w_accept;
   logic           w_err;
   logic [AW-1:0]  w_idx;
   logic [1:0]     w_off;
   logic [31:0]    w_word;
   logic [7:0]     w_byte;
   logic [15:0]    w_half;
   logic [3:0]     w_be;
   logic [31:0]    w_lanes;
   logic [31:0]    w_merged;
   logic [31:0]    w_loadData;
   logic [31:0]    w_rspData;
   logic           w_unusedAddrBits;

   assign w_idx            = bus.req_addr[AW+1:2];
   assign w_off            = bus.req_addr[1:0];
   assign w_unusedAddrBits = ^bus.req_addr[31:AW+2];
   assign w_accept         = bus.req_valid && w_ready;
   assign w_word           = r_mem[w_idx];
   assign w_byte           = w_word[{w_off, 3'b000} +: 8];
   assign w_half           = w_word[{w_off[1], 4'b0000} +: 16];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_INIT;
         r_clrCnt <= '0;
      end else begin
         r_state <= w_nextState;
         if (r_state == ST_INIT)
            r_clrCnt <= r_clrCnt + 1'b1;
      end
   end

   // INIT leaves on the same edge that clears the last word.
   always_comb begin
      w_nextState = r_state;
      w_ready     = 1'b0;
      w_initDone  = 1'b0;
      case (r_state)
         ST_INIT: begin
            if (r_clrCnt == AW'(DEPTH_WORDS - 1))
               w_nextState = ST_READY;
         end
         ST_READY: begin
            w_ready    = 1'b1;
            w_initDone = 1'b1;
         end
         default: w_nextState = ST_INIT;
      endcase
   end

   // Unsigned load sizes (100/101) have no store counterpart, hence illegal when writing.
   always_comb begin
      w_err = 1'b0;
      case (bus.req_funct3)
         3'b000:  w_err = 1'b0;
         3'b001:  w_err = w_off[0];
         3'b010:  w_err = (w_off != 2'b00);
         3'b100:  w_err = bus.req_we;
         3'b101:  w_err = bus.req_we || w_off[0];
         default: w_err = 1'b1;
      endcase
   end

   always_comb begin
      w_be    = 4'b1111;
      w_lanes = bus.req_wdata;
      case (bus.req_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_off;
            w_lanes = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << w_off;
            w_lanes = {2{bus.req_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_lanes = bus.req_wdata;
         end
      endcase
      w_merged = w_word;
      for (int i = 0; i < 4; i++)
         if (w_be[i])
            w_merged[8*i +: 8] = w_lanes[8*i +: 8];
   end

   always_comb begin
      w_loadData = 32'h0;
      case (bus.req_funct3)
         3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_loadData = {24'h0, w_byte};
         3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
         3'b101:  w_loadData = {16'h0, w_half};
         3'b010:  w_loadData = w_word;
         default: w_loadData = 32'h0;
      endcase
      w_rspData = (w_err || bus.req_we) ? 32'h0 : w_loadData;
   end

   // Memory carries no reset; the INIT sweep is what defines its contents.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (r_state == ST_INIT)
            r_mem[r_clrCnt] <= 32'h0;
         else if (w_accept && bus.req_we && !w_err)
            r_mem[w_idx] <= w_merged;
      end
   end

`ifdef DMEM_LSU_REG_READ_EN
   logic        r_rspValid;
   logic [31:0] r_rspData;
   logic        r_rspErr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rspValid <= 1'b0;
         r_rspData  <= 32'h0;
         r_rspErr   <= 1'b0;
      end else begin
         r_rspValid <= w_accept;
         r_rspData  <= w_accept ? w_rspData : 32'h0;
         r_rspErr   <= w_accept && w_err;
      end
   end

   assign bus.rsp_valid = r_rspValid;
   assign bus.rsp_rdata = r_rspData;
   assign bus.rsp_err   = r_rspErr;
`else
   assign bus.rsp_valid = w_accept;
   assign bus.rsp_rdata = w_accept ? w_rspData : 32'h0;
   assign bus.rsp_err   = w_accept && w_err;
`endif

   assign bus.ready     = w_ready;
   assign bus.init_done = w_initDone;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomised scoreboard bench for dmem_lsu (DEPTH_WORDS=16) against a byte-array memory model.
module tb_dmem_lsu;

   localparam int DEPTH = 16;
   localparam int BYTES = DEPTH * 4;

   typedef struct {
      string       name;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst_n;
   dmem_lsu_if bus();

   dmem_lsu #(.DEPTH_WORDS(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          compared   = 0;
   int          mismatched = 0;
   exp_t        expQ[$];
   logic [7:0]  model [BYTES];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: memory is a flat little-endian byte array; sizes and legality follow RV32I funct3.
   function automatic void modelAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wdata, output logic expErr, output logic [31:0] expData);
      int     size;
      bit     sgn;
      bit     ok;
      int     a;
      longint v;
      a = int'(addr % BYTES);
      ok = 1; size = 1; sgn = 0;
      case (f3)
         3'd0: begin size = 1; sgn = 1; end
         3'd1: begin size = 2; sgn = 1; end
         3'd2: begin size = 4; sgn = 0; end
         3'd4: begin size = 1; sgn = 0; ok = !we; end
         3'd5: begin size = 2; sgn = 0; ok = !we; end
         default: ok = 0;
      endcase
      if (ok && (a % size) != 0) ok = 0;
      expErr = !ok;
      expData = 32'h0;
      if (ok && we) begin
         for (int i = 0; i < size; i++) model[a + i] = wdata[8*i +: 8];
      end else if (ok) begin
         v = 0;
         for (int i = 0; i < size; i++) v += longint'(model[a + i]) << (8 * i);
         if (sgn && v >= (longint'(1) << (8 * size - 1))) v -= (longint'(1) << (8 * size));
         expData = v[31:0];
      end
   endfunction

   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input string name);
      int   guard;
      exp_t e;
      guard = 0;
      while (!bus.ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!bus.ready) begin
         checkOutput({name, "_ready_timeout"}, 32'(bus.ready), 32'h1);
         return;
      end
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      e.name = name;
      modelAccess(we, f3, addr, wdata, e.err, e.data);
      expQ.push_back(e);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic countReadyDelay(input string name);
      int cycles;
      rst_n = 1'b1;
      cycles = 0;
      do begin
         @(posedge clk); #1;
         cycles++;
      end while (!bus.ready && cycles < 100);
      checkOutput({name, "_ready_delay"}, 32'(cycles), 32'(DEPTH));
      checkOutput({name, "_init_done"}, 32'(bus.init_done), 32'h1);
      for (int i = 0; i < BYTES; i++) model[i] = 8'h0;
   endtask

   task automatic readAllWords(input string name);
      for (int w = 0; w < DEPTH; w++)
         applyStimulus(1'b0, 3'b010, 32'(w * 4), 32'h0, name);
   endtask

   // Monitor: every response pops the oldest expectation, independent of response latency.
   always @(negedge clk) begin
      exp_t e;
      if (bus.rsp_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
         end else begin
            e = expQ.pop_front();
            checkOutput({e.name, "_rdata"}, bus.rsp_rdata, e.data);
            checkOutput({e.name, "_err"}, 32'(bus.rsp_err), 32'(e.err));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_ready",     32'(bus.ready),     32'h0);
      checkOutput("rst_init_done", 32'(bus.init_done), 32'h0);
      checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      checkOutput("rst_rsp_rdata", bus.rsp_rdata,      32'h0);
      checkOutput("rst_rsp_err",   32'(bus.rsp_err),   32'h0);

      countReadyDelay("first_init");
      readAllWords("cleared");

      applyStimulus(1'b1, 3'b010, 32'h04, 32'hA5A5A5A5, "sw_04");
      applyStimulus(1'b0, 3'b010, 32'h04, 32'h0,        "lw_04");
      applyStimulus(1'b1, 3'b010, 32'h08, 32'h00000000, "sw_08");
      applyStimulus(1'b1, 3'b000, 32'h09, 32'h00000080, "sb_09");
      applyStimulus(1'b0, 3'b010, 32'h08, 32'h0,        "lw_08");
      applyStimulus(1'b0, 3'b000, 32'h09, 32'h0,        "lb_09");
      applyStimulus(1'b0, 3'b100, 32'h09, 32'h0,        "lbu_09");
      applyStimulus(1'b1, 3'b010, 32'h0C, 32'h11223344, "sw_0c");
      applyStimulus(1'b0, 3'b001, 32'h0E, 32'h0,        "lh_0e");
      applyStimulus(1'b0, 3'b001, 32'h0D, 32'h0,        "lh_0d_mis");
      applyStimulus(1'b1, 3'b010, 32'h0E, 32'hFFFFFFFF, "sw_0e_mis");
      applyStimulus(1'b0, 3'b010, 32'h0C, 32'h0,        "lw_0c_kept");
      applyStimulus(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, "sw_40_wrap");
      applyStimulus(1'b0, 3'b010, 32'h00, 32'h0,        "lw_00_wrap");
      applyStimulus(1'b1, 3'b101, 32'h10, 32'h1234,     "shu_illegal");
      applyStimulus(1'b0, 3'b011, 32'h10, 32'h0,        "f3_011");
      applyStimulus(1'b0, 3'b101, 32'h0E, 32'h0,        "lhu_0e");

      for (int n = 0; n < 300; n++) begin
         we   = 1'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         addr = $urandom();
         applyStimulus(we, f3, addr, $urandom(), "rand");
      end
      readAllWords("rand_final");

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("midinit_ready_low", 32'(bus.ready), 32'h0);
      countReadyDelay("mid_init");
      readAllWords("after_midinit");

      repeat (3) @(posedge clk);
      #1;
      checkOutput("pending_rsp_left", 32'(expQ.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
